word_serializer: RTL

WORD_SERIALIZER -- requirements
Module: word_serializer

---
 rtl/word_serializer.sv | 63 ++++++
 1 files changed

// File: rtl/word_serializer.sv
// word_serializer: parallel-to-serial shifter, LSB first, with hold stall and back-to-back word chaining.
module word_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             hold,
  output logic             ser_bit,
  output logic             ser_start,
  output logic             word_done,
  output logic             busy
);
  localparam int IW = $clog2(WIDTH);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  logic [0:0]       r_state;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_sr;
  logic             w_last;
  logic             w_accept;
  // r_idx is the index of the bit currently on ser_bit
  assign w_last    = (r_state == SHIFT) && (r_idx == IW'(WIDTH-1));
  assign din_ready = !hold && ((r_state == IDLE) || w_last);
  assign w_accept  = din_valid && din_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_sr      <= '0;
      ser_bit   <= 1'b0;
      ser_start <= 1'b0;
      word_done <= 1'b0;
      busy      <= 1'b0;
    end else if (!hold) begin
      if (w_accept) begin
        r_state   <= SHIFT;
        r_idx     <= '0;
        r_sr      <= din;
        ser_bit   <= din[0];
        ser_start <= 1'b1;
        word_done <= 1'b0;
        busy      <= 1'b1;
      end else if (w_last) begin
        r_state   <= IDLE;
        r_idx     <= '0;
        r_sr      <= '0;
        ser_bit   <= 1'b0;
        ser_start <= 1'b0;
        word_done <= 1'b0;
        busy      <= 1'b0;
      end else if (r_state == SHIFT) begin
        r_idx     <= r_idx + 1'b1;
        r_sr      <= r_sr >> 1;
        ser_bit   <= r_sr[1];
        ser_start <= 1'b0;
        word_done <= (r_idx == IW'(WIDTH-2));
      end
    end
  end
endmodule
